mac_acc_4bit: RTL

Sequential dot-product accumulator wrapped around the combinational 4-bit multiply-accumulate unit (`MAC_4bit`). It accepts a stream of 4-bit unsigned operand pairs over a valid/ready handshake and feeds the running 12-bit sum back as the MAC `c` input each beat. After the programmed number of pairs it presents the final sum and an overflow flag on a registered valid/ready output. It sits between the operand fetch logic (upstream) and the result writeback (downstream).

---
 rtl/mac_acc_pkg.sv | 16 +
 rtl/MAC_4bit.sv | 23 ++
 rtl/mac_acc_4bit.sv | 97 +++++++++
 3 files changed

// File: rtl/mac_acc_pkg.sv
// mac_acc_pkg: shared widths, saturation limit and FSM state type for the MAC dot-product accumulator
package mac_acc_pkg;

    localparam int OP_W  = 4;
    localparam int ACC_W = 12;
    localparam int LEN_W = 4;

    localparam logic [ACC_W-1:0] ACC_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } mac_acc_state_t;

endpackage

// File: rtl/MAC_4bit.sv
// MAC_4bit: combinational unsigned 4x4 multiply plus 12-bit addend, 13-bit sum split into result and carry-out
module MAC_4bit
    import mac_acc_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [ACC_W-1:0] c,
    output logic [ACC_W-1:0] result,
    output logic             cout
);

    logic [2*OP_W-1:0] prod;
    logic [ACC_W:0]    sum;

    // The product never exceeds 225, so only the addend can push the sum into bit 12
    always_comb begin
        prod   = a * b;
        sum    = {{(ACC_W+1-2*OP_W){1'b0}}, prod} + {1'b0, c};
        result = sum[ACC_W-1:0];
        cout   = sum[ACC_W];
    end

endmodule

// File: rtl/mac_acc_4bit.sv
// mac_acc_4bit: streaming dot-product accumulator around MAC_4bit with valid/ready in and out.
// Define MAC_SAT_EN to clamp the accumulator at 12'hFFF on carry-out instead of wrapping.
module mac_acc_4bit
    import mac_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    mac_acc_state_t   state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, mac_res;
    logic [LEN_W-1:0] cnt;
    logic             ovf, ovf_nxt, mac_cout;
    logic             beat, last_beat;

    MAC_4bit u_mac (
        .a      (a),
        .b      (b),
        .c      (acc),
        .result (mac_res),
        .cout   (mac_cout)
    );

    assign in_ready  = (state == ACC);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;
    assign last_beat = beat & (cnt == '0);

    // Accumulator update for the current beat: wrap by default, clamp when saturation is built in
    always_comb begin
        acc_nxt = (SAT && mac_cout) ? ACC_MAX : mac_res;
        ovf_nxt = ovf | mac_cout;
    end

    // Next-state decode; start only matters in IDLE and is never remembered elsewhere
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ACC : IDLE;
            ACC:     state_nxt = last_beat ? OUT : ACC;
            OUT:     state_nxt = out_ready ? IDLE : OUT;
            default: state_nxt = IDLE;
        endcase
    end

    // State, accumulator, counter and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                acc <= bias;
                cnt <= len;
                ovf <= 1'b0;
            end
            if (beat) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
            end
            if (last_beat) begin
                out_valid <= 1'b1;
                out_data  <= acc_nxt;
                out_ovf   <= ovf_nxt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
